// File: rtl/core_bus_arb.sv
// ---------------------------------------------------------------------------
// core_bus_arb
//   Two-master / one-slave bus arbiter sitting directly behind the core.
//   Master 0 is the instruction bus and master 1 is the data bus. Only one
//   transaction is outstanding at a time. The data bus wins by default. A
//   starvation counter forces an instruction-bus grant after STARVE_LIMIT
//   consecutive data-bus grants made while the instruction bus was waiting.
//   A response timeout turns a silent slave into an error response so the
//   core never hangs.
//
// Parameters
//   STARVE_LIMIT   : dbus grants tolerated while ibus waits (1..15)
//   TIMEOUT_CYCLES : silent WAIT_RSP cycles before an error response (1..255)
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   m0_* / m1_*            : ibus / dbus request (addr, data, sel, we,
//                            req_valid -> req_ready) and response
//                            (rsp_valid, data_o <- rsp_ready)
//   s_addr_o .. s_we_o     : request fields of the granted master
//   s_req_valid_o/_ready_i : slave request handshake
//   s_rsp_valid_i/_ready_o : slave response handshake, s_data_i read data
//   timeout_o              : high while an error response is presented
// ---------------------------------------------------------------------------
module core_bus_arb #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0 : instruction bus
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  output logic        m0_rsp_valid_o,
  input  logic        m0_rsp_ready_i,
  output logic [31:0] m0_data_o,
  // master 1 : data bus
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  output logic        m1_rsp_valid_o,
  input  logic        m1_rsp_ready_i,
  output logic [31:0] m1_data_o,
  // slave port
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_req_valid_o,
  input  logic        s_req_ready_i,
  input  logic        s_rsp_valid_i,
  output logic        s_rsp_ready_o,
  input  logic [31:0] s_data_i,
  output logic        timeout_o
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] LP_TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    ERR_RSP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;      // 0 = m0 (ibus), 1 = m1 (dbus)
  logic [3:0]  r_starve_cnt;
  logic [7:0]  r_to_cnt;

  logic        w_gnt_m0;
  logic        w_gnt_m1;
  logic        w_any_req;
  logic        w_accept;
  logic        w_own_rsp_ready;
  logic        w_in_err;

  // Arbitration: dbus wins unless the ibus has been passed over too often.
  assign w_gnt_m0  = m0_req_valid_i &
                     (~m1_req_valid_i | (r_starve_cnt == LP_STARVE_MAX));
  assign w_gnt_m1  = m1_req_valid_i & ~w_gnt_m0;
  assign w_any_req = m0_req_valid_i | m1_req_valid_i;

  // Request fields follow the grant; with no requester they default to m1.
  assign s_addr_o = w_gnt_m0 ? m0_addr_i : m1_addr_i;
  assign s_data_o = w_gnt_m0 ? m0_data_i : m1_data_i;
  assign s_sel_o  = w_gnt_m0 ? m0_sel_i  : m1_sel_i;
  assign s_we_o   = w_gnt_m0 ? m0_we_i   : m1_we_i;

  assign w_own_rsp_ready = r_owner ? m1_rsp_ready_i : m0_rsp_ready_i;
  assign w_in_err        = (r_state == ERR_RSP);

  // Read data is passed straight through; only rsp_valid qualifies it.
  assign m0_data_o = w_in_err ? 32'h0 : s_data_i;
  assign m1_data_o = w_in_err ? 32'h0 : s_data_i;

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    s_req_valid_o  = 1'b0;
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    m0_rsp_valid_o = 1'b0;
    m1_rsp_valid_o = 1'b0;
    s_rsp_ready_o  = 1'b1;
    timeout_o      = 1'b0;

    case (r_state)
      IDLE: begin
        // rst_n gating keeps the request handshake quiet while reset is held,
        // even if masters keep their requests up across the reset.
        s_req_valid_o  = w_any_req & rst_n;
        m0_req_ready_o = w_gnt_m0 & s_req_ready_i & rst_n;
        m1_req_ready_o = w_gnt_m1 & s_req_ready_i & rst_n;
        w_accept       = w_any_req & s_req_ready_i & rst_n;
        if (w_accept) begin
          w_state_nxt = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        m0_rsp_valid_o = ~r_owner & s_rsp_valid_i;
        m1_rsp_valid_o =  r_owner & s_rsp_valid_i;
        s_rsp_ready_o  = w_own_rsp_ready;
        if (s_rsp_valid_i && w_own_rsp_ready) begin
          w_state_nxt = IDLE;
        end else if (!s_rsp_valid_i && (r_to_cnt == LP_TO_LAST)) begin
          w_state_nxt = ERR_RSP;
        end
      end

      ERR_RSP: begin
        // Any late slave response is absorbed here and dropped.
        m0_rsp_valid_o = ~r_owner;
        m1_rsp_valid_o =  r_owner;
        timeout_o      = 1'b1;
        if (w_own_rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, owner, starvation and timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_to_cnt     <= 8'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_owner  <= w_gnt_m1;
        r_to_cnt <= 8'd0;
        if (w_gnt_m0) begin
          r_starve_cnt <= 4'd0;
        end else if (m0_req_valid_i && (r_starve_cnt != LP_STARVE_MAX)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else if ((r_state == WAIT_RSP) && !s_rsp_valid_i &&
                   (r_to_cnt != LP_TO_LAST)) begin
        // A valid response held off by owner backpressure does not age.
        r_to_cnt <= r_to_cnt + 8'd1;
      end
    end
  end

endmodule
